// File: rtl/uart_hex_formatter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_hex_formatter
//  Brief    : Captures a 32-bit count and streams it to a UART transmitter as
//             ASCII hex, most-significant nibble first, optionally with CR LF.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_hex_formatter #(
    parameter int NUM_DIGITS = 8,
    parameter int EMIT_CRLF  = 1,
    parameter int UPPERCASE  = 1
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic [31:0] i_count,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_dropped,
    output logic [7:0]  o_uart_data,
    output logic        o_uart_start,
    input  logic        i_uart_busy
);

    localparam int         c_LEN        = NUM_DIGITS + 2 * EMIT_CRLF;
    localparam logic [3:0] c_DIGITS     = 4'(NUM_DIGITS);
    localparam logic [3:0] c_LAST_DIGIT = 4'(NUM_DIGITS - 1);
    localparam logic [3:0] c_LAST_IDX   = 4'(c_LEN - 1);
    localparam logic [7:0] c_ALPHA_BASE = (UPPERCASE != 0) ? 8'h41 : 8'h61;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_IDLE = 3'd1;
    localparam logic [2:0] S_SEND      = 3'd2;
    localparam logic [2:0] S_ACK       = 3'd3;
    localparam logic [2:0] S_DRAIN     = 3'd4;

    logic [2:0]  r_state;
    logic [31:0] r_snapshot;
    logic [3:0]  r_idx;
    logic [7:0]  r_data;

    logic [3:0]  w_next_idx;
    logic [3:0]  w_digit_pos;
    logic [3:0]  w_nibble;
    logic [7:0]  w_char;

    // Character for the index about to be sent: 0 from WAIT_IDLE, k+1 from DRAIN.
    always_comb begin
        w_next_idx  = (r_state == S_DRAIN) ? (r_idx + 4'd1) : 4'd0;
        w_digit_pos = c_LAST_DIGIT - w_next_idx;
        w_nibble    = 4'(r_snapshot >> {w_digit_pos, 2'b00});
        w_char      = 8'h00;
        if (w_next_idx < c_DIGITS) begin
            if (w_nibble < 4'd10) begin
                w_char = 8'h30 + {4'h0, w_nibble};
            end else begin
                w_char = c_ALPHA_BASE + {4'h0, w_nibble} - 8'd10;
            end
        end else if (w_next_idx == c_DIGITS) begin
            w_char = 8'h0D;
        end else begin
            w_char = 8'h0A;
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_snapshot <= 32'h0;
            r_idx      <= 4'd0;
            r_data     <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_snapshot <= i_count;
                        r_idx      <= 4'd0;
                        r_state    <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (!i_uart_busy) begin
                        r_data  <= w_char;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    if (i_uart_busy) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!i_uart_busy) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= w_next_idx;
                            r_data  <= w_char;
                            r_state <= S_SEND;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The DRAIN->IDLE cycle still reports not-ready, so a strobe there is dropped.
    assign o_ready      = (r_state == S_IDLE);
    assign o_dropped    = i_valid && (r_state != S_IDLE);
    assign o_uart_start = (r_state == S_SEND);
    assign o_uart_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_formatter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_hex_formatter
//  Brief    : Three parameterisations of uart_hex_formatter, each with a UART
//             busy model, checked against a plain-arithmetic hex model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_hex_formatter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid   [3];
    logic [31:0] cnt     [3];
    logic        ready   [3];
    logic        dropped [3];
    logic [7:0]  udata   [3];
    logic        ustart  [3];
    logic        ubusy   [3];
    bit          mbusy      [3];
    bit          force_busy [3];
    bit          pend       [3];
    int          bcnt       [3];

    logic [7:0]  got   [3][1024];
    int          got_n [3];
    int          drop_n[3];

    int nd_t   [3] = '{8, 8, 4};
    int crlf_t [3] = '{1, 0, 0};
    int up_t   [3] = '{1, 0, 1};

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_hex_formatter u0 (
        .clk(clk), .i_reset(rst_n), .i_count(cnt[0]), .i_valid(valid[0]),
        .o_ready(ready[0]), .o_dropped(dropped[0]), .o_uart_data(udata[0]),
        .o_uart_start(ustart[0]), .i_uart_busy(ubusy[0])
    );

    uart_hex_formatter #(.NUM_DIGITS(8), .EMIT_CRLF(0), .UPPERCASE(0)) u1 (
        .clk(clk), .i_reset(rst_n), .i_count(cnt[1]), .i_valid(valid[1]),
        .o_ready(ready[1]), .o_dropped(dropped[1]), .o_uart_data(udata[1]),
        .o_uart_start(ustart[1]), .i_uart_busy(ubusy[1])
    );

    uart_hex_formatter #(.NUM_DIGITS(4), .EMIT_CRLF(0), .UPPERCASE(1)) u2 (
        .clk(clk), .i_reset(rst_n), .i_count(cnt[2]), .i_valid(valid[2]),
        .o_ready(ready[2]), .o_dropped(dropped[2]), .o_uart_data(udata[2]),
        .o_uart_start(ustart[2]), .i_uart_busy(ubusy[2])
    );

    assign ubusy[0] = mbusy[0] | force_busy[0];
    assign ubusy[1] = mbusy[1] | force_busy[1];
    assign ubusy[2] = mbusy[2] | force_busy[2];

    // UART model: busy rises one cycle after a start and stays high 10 cycles.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (pend[i]) begin
                mbusy[i] <= 1'b1;
                bcnt[i]  <= 10;
                pend[i]  <= 1'b0;
            end else if (bcnt[i] > 0) begin
                bcnt[i] <= bcnt[i] - 1;
                if (bcnt[i] == 1) mbusy[i] <= 1'b0;
            end
            if (ustart[i] === 1'b1) pend[i] <= 1'b1;
        end
    end

    // Byte capture and drop counting, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ustart[i] === 1'b1) begin
                if (got_n[i] < 1024) got[i][got_n[i]] <= udata[i];
                got_n[i] <= got_n[i] + 1;
            end
            if (dropped[i] === 1'b1) drop_n[i] <= drop_n[i] + 1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_char(logic [31:0] v, int nd, int up, int k);
        int n;
        if (k < nd) begin
            n = int'((v >> (4 * (nd - 1 - k))) & 32'hF);
            if (n < 10) return 8'(48 + n);
            return 8'(((up != 0) ? 65 : 97) + n - 10);
        end
        return (k == nd) ? 8'h0D : 8'h0A;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [2:0] mask, logic [31:0] v0, logic [31:0] v1, logic [31:0] v2);
        if (mask[0]) begin valid[0] = 1'b1; cnt[0] = v0; end
        if (mask[1]) begin valid[1] = 1'b1; cnt[1] = v1; end
        if (mask[2]) begin valid[2] = 1'b1; cnt[2] = v2; end
        tick();
        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b0;
            cnt[i]   = $urandom;
        end
    endtask

    task automatic wait_all(logic [2:0] mask, string tag);
        int cyc = 0;
        while (cyc < 400 && ((mask & ~{ready[2], ready[1], ready[0]}) != 3'b000)) begin
            tick();
            cyc++;
        end
        chk({tag, " idle timeout"}, 32'(cyc < 400), 32'd1);
    endtask

    task automatic check_msg(int i, int base, logic [31:0] v, string tag);
        int len = nd_t[i] + 2 * crlf_t[i];
        chk($sformatf("%s u%0d length", tag, i), 32'(got_n[i] - base), 32'(len));
        for (int k = 0; k < len && base + k < 1024; k++)
            chk($sformatf("%s u%0d char%0d", tag, i, k), {24'h0, got[i][base + k]},
                {24'h0, exp_char(v, nd_t[i], up_t[i], k)});
    endtask

    initial begin
        int b[3];
        int b2;
        int d0;
        int cyc;
        logic [31:0] v[3];

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b0;
            cnt[i]   = 32'h0;
        end
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset u%0d ready", i), 32'(ready[i]), 32'd1);
            chk($sformatf("reset u%0d dropped", i), 32'(dropped[i]), 32'd0);
            chk($sformatf("reset u%0d start", i), 32'(ustart[i]), 32'd0);
            chk($sformatf("reset u%0d data", i), {24'h0, udata[i]}, 32'h0);
        end
        rst_n = 1'b1;
        tick();
        tick();

        // Directed vectors from all three parameterisations, plus latency.
        for (int i = 0; i < 3; i++) b[i] = got_n[i];
        send(3'b111, 32'h1234ABCD, 32'hDEADBEEF, 32'hFFFF00F0);
        chk("latency u0 ready low", 32'(ready[0]), 32'd0);
        chk("latency u0 no early start", 32'(ustart[0]), 32'd0);
        tick();
        chk("latency u0 start", 32'(ustart[0]), 32'd1);
        chk("latency u0 first byte", {24'h0, udata[0]}, 32'h31);
        chk("latency u1 first byte", {24'h0, udata[1]}, 32'h64);
        chk("latency u2 first byte", {24'h0, udata[2]}, 32'h30);
        wait_all(3'b111, "directed");
        check_msg(0, b[0], 32'h1234ABCD, "directed");
        check_msg(1, b[1], 32'hDEADBEEF, "directed");
        check_msg(2, b[2], 32'hFFFF00F0, "directed");

        // Random counts on all instances.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) begin
                b[i] = got_n[i];
                v[i] = $urandom;
            end
            send(3'b111, v[0], v[1], v[2]);
            wait_all(3'b111, "random");
            for (int i = 0; i < 3; i++) check_msg(i, b[i], v[i], $sformatf("random%0d", r));
        end

        // Strobe while busy sending is dropped and leaves the snapshot intact.
        b[0] = got_n[0];
        d0   = drop_n[0];
        send(3'b001, 32'h00000000, 32'h0, 32'h0);
        cyc = 0;
        while (cyc < 400 && (got_n[0] - b[0]) < 3) begin
            tick();
            cyc++;
        end
        chk("drop reach 3rd char", 32'(cyc < 400), 32'd1);
        valid[0] = 1'b1;
        cnt[0]   = 32'h11111111;
        #1;
        chk("drop pulse", 32'(dropped[0]), 32'd1);
        chk("drop not ready", 32'(ready[0]), 32'd0);
        tick();
        valid[0] = 1'b0;
        wait_all(3'b001, "drop");
        check_msg(0, b[0], 32'h00000000, "drop");
        chk("drop count", 32'(drop_n[0] - d0), 32'd1);

        // Busy high at capture stalls without start pulses.
        b[0]          = got_n[0];
        v[0]          = $urandom;
        force_busy[0] = 1'b1;
        send(3'b001, v[0], 32'h0, 32'h0);
        for (int c = 0; c < 50; c++) tick();
        chk("stall no start", 32'(got_n[0] - b[0]), 32'd0);
        force_busy[0] = 1'b0;
        #1;
        chk("stall start not yet", 32'(ustart[0]), 32'd0);
        tick();
        chk("stall start after busy low", 32'(ustart[0]), 32'd1);
        wait_all(3'b001, "stall");
        check_msg(0, b[0], v[0], "stall");

        // Reset during the 5th character's DRAIN abandons the message.
        b[0] = got_n[0];
        send(3'b001, $urandom, 32'h0, 32'h0);
        cyc = 0;
        while (cyc < 400 && !((got_n[0] - b[0]) >= 5 && ubusy[0] === 1'b1)) begin
            tick();
            cyc++;
        end
        chk("midreset reach 5th drain", 32'(cyc < 400), 32'd1);
        tick();
        force_busy[0] = 1'b1;
        rst_n         = 1'b0;
        #1;
        chk("midreset ready", 32'(ready[0]), 32'd1);
        chk("midreset start", 32'(ustart[0]), 32'd0);
        chk("midreset data", {24'h0, udata[0]}, 32'h0);
        chk("midreset dropped", 32'(dropped[0]), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        b2    = got_n[0];
        chk("midreset chars sent", 32'(b2 - b[0]), 32'd5);
        tick();
        v[0] = $urandom;
        send(3'b001, v[0], 32'h0, 32'h0);
        for (int c = 0; c < 20; c++) tick();
        chk("midreset no start while busy", 32'(got_n[0] - b2), 32'd0);
        force_busy[0] = 1'b0;
        wait_all(3'b001, "midreset");
        check_msg(0, b2, v[0], "midreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
